// File: rtl/regfile_scoreboard_pkg.sv
// Shared constants and FSM state type for the register-file hazard scoreboard.
//   NREG      : number of architectural registers
//   AW        : register address width
//   CNT_W_DEF : default width of the saturating stall-cycle counter
//   sb_state_e: issue sequencer states (RUN, DRAIN, HALTED)
package regfile_scoreboard_pkg;

  localparam int unsigned NREG      = 8;
  localparam int unsigned AW        = 3;
  localparam int unsigned CNT_W_DEF = 16;

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_DRAIN  = 2'd1,
    ST_HALTED = 2'd2
  } sb_state_e;

endpackage

// File: rtl/regfile_scoreboard_busy_bit.sv
// Pending-write flag for one architectural register.
//   clk, reset : clock, asynchronous active-high reset
//   set_i      : an instruction writing this register issues this cycle
//   clr_i      : write-back to this register this cycle
//   busy_q_o   : registered pending-write flag
// A same-cycle set overrides the clear so a re-issued writer keeps the register busy.
module sb_busy_bit (
  input  logic clk,
  input  logic reset,
  input  logic set_i,
  input  logic clr_i,
  output logic busy_q_o
);

  logic busy_d;

  always_comb begin
    busy_d = (busy_q_o & ~clr_i) | set_i;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      busy_q_o <= 1'b0;
    end else begin
      busy_q_o <= busy_d;
    end
  end

endmodule

// File: rtl/regfile_scoreboard.sv
// Decode-stage hazard scoreboard and issue sequencer for an 8 x 16-bit register file.
//   clk, reset            : clock, asynchronous active-high reset
//   issue_valid           : decode presents an instruction
//   src_addr / src_used   : source register and whether it is read
//   dst_addr / dst_used   : destination register and whether it is read
//   wr_en                 : instruction writes dst_addr at write-back
//   wb_valid / wb_addr    : write-back port
//   halt_req              : level request to stop issue and drain pending writes
//   stall, issue_fire     : combinational decode handshake
//   busy_mask             : registered per-register pending-write bits
//   drained               : registered, high while HALTED
//   stall_cycles          : registered saturating count of stalled issue cycles
module regfile_scoreboard
  import regfile_scoreboard_pkg::*;
#(
  parameter int unsigned CNT_W = CNT_W_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              issue_valid,
  input  logic [AW-1:0]     src_addr,
  input  logic [AW-1:0]     dst_addr,
  input  logic              src_used,
  input  logic              dst_used,
  input  logic              wr_en,
  input  logic              wb_valid,
  input  logic [AW-1:0]     wb_addr,
  input  logic              halt_req,
  output logic              stall,
  output logic              issue_fire,
  output logic [NREG-1:0]   busy_mask,
  output logic              drained,
  output logic [CNT_W-1:0]  stall_cycles
);

  sb_state_e        state_q, state_d;
  logic             drained_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [NREG-1:0]  busy_q, wb_clr, busy_set, eff_busy;
  logic             hazard;

  // Write-back clears and issue sets, decoded one-hot per register.
  always_comb begin
    wb_clr   = '0;
    busy_set = '0;
    if (wb_valid) begin
      wb_clr[wb_addr] = 1'b1;
    end
    if (issue_fire & wr_en) begin
      busy_set[dst_addr] = 1'b1;
    end
  end

  // A register being written back this cycle is already free for readers.
  assign eff_busy = busy_q & ~wb_clr;
  assign hazard   = (src_used & eff_busy[src_addr])
                  | ((dst_used | wr_en) & eff_busy[dst_addr]);

  // Sequencer next state and stall.
  always_comb begin
    state_d = state_q;
    stall   = 1'b0;
    case (state_q)
      ST_RUN: begin
        stall = hazard;
        if (halt_req) state_d = ST_DRAIN;
      end
      ST_DRAIN: begin
        stall = 1'b1;
        if (!halt_req)           state_d = ST_RUN;
        else if (eff_busy == '0) state_d = ST_HALTED;
      end
      ST_HALTED: begin
        stall = 1'b1;
        if (!halt_req) state_d = ST_RUN;
      end
      default: begin
        state_d = ST_RUN;
      end
    endcase
    // Handshake is quiet while reset is held.
    if (reset) stall = 1'b0;
  end

  assign issue_fire = issue_valid & ~stall & ~reset;

  // Saturating stall counter.
  always_comb begin
    cnt_d = cnt_q;
    if (issue_valid & stall & (cnt_q != {CNT_W{1'b1}})) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= ST_RUN;
      drained_q <= 1'b0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      drained_q <= (state_d == ST_HALTED);
      cnt_q     <= cnt_d;
    end
  end

  for (genvar r = 0; r < NREG; r++) begin : g_busy
    sb_busy_bit u_busy (
      .clk      (clk),
      .reset    (reset),
      .set_i    (busy_set[r]),
      .clr_i    (wb_clr[r]),
      .busy_q_o (busy_q[r])
    );
  end

  assign busy_mask    = busy_q;
  assign drained      = drained_q;
  assign stall_cycles = cnt_q;

endmodule
